// File: rtl/bn_stream_fold.sv
// Streaming folded batch-norm with per-channel coefficient file, frame sequencer
// and a 3-stage valid/ready pipeline that stalls as a single unit.
module bn_stream_fold #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int LANES      = 8,
  parameter int CHANNELS   = 64,
  parameter int CH_W       = 6
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [1:0]                  cfg_mode,
  input  logic [CH_W-1:0]             cfg_ch_m1,
  input  logic [15:0]                 cfg_beats_m1,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_WIDTH*LANES-1:0] in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_WIDTH*LANES-1:0] out_data,
  output logic [CH_W-1:0]             out_ch,
  output logic                        out_last,
  output logic                        busy,
  output logic                        done,
  input  logic                        coef_we,
  input  logic [CH_W-1:0]             coef_addr,
  input  logic [DATA_WIDTH-1:0]       coef_scale,
  input  logic [DATA_WIDTH-1:0]       coef_bias,
  output logic                        coef_err
);
  localparam int PW = 2 * DATA_WIDTH;
  localparam int LW = DATA_WIDTH * LANES;
  localparam logic signed [PW:0] RND     = (PW+1)'(2 ** (FRAC_BITS - 1));
  localparam logic signed [PW:0] SAT_MAX = (PW+1)'(2 ** (DATA_WIDTH - 1) - 1);
  localparam logic signed [PW:0] SAT_MIN = (PW+1)'(-(2 ** (DATA_WIDTH - 1)));
  localparam logic signed [DATA_WIDTH+7:0] LEAKY_K = (DATA_WIDTH+8)'(26);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DRAIN = 2'd2} state_t;

  function automatic logic signed [PW-1:0] mul_lane(input logic signed [DATA_WIDTH-1:0] a,
                                                    input logic signed [DATA_WIDTH-1:0] b);
    mul_lane = $signed({{DATA_WIDTH{a[DATA_WIDTH-1]}}, a}) * $signed({{DATA_WIDTH{b[DATA_WIDTH-1]}}, b});
  endfunction

  // Round-half-up, add bias, saturate, then activation; leaky slope 26/256 floors.
  function automatic logic [DATA_WIDTH-1:0] bn_lane(input logic signed [PW-1:0] p,
                                                    input logic [DATA_WIDTH-1:0] b,
                                                    input logic [1:0] mode);
    logic signed [PW:0]           r;
    logic signed [PW:0]           s;
    logic signed [DATA_WIDTH-1:0] y;
    logic signed [DATA_WIDTH+7:0] lk;
    r = ($signed({p[PW-1], p}) + RND) >>> FRAC_BITS;
    s = r + $signed({{(PW+1-DATA_WIDTH){b[DATA_WIDTH-1]}}, b});
    if (s > SAT_MAX) y = SAT_MAX[DATA_WIDTH-1:0];
    else if (s < SAT_MIN) y = SAT_MIN[DATA_WIDTH-1:0];
    else y = s[DATA_WIDTH-1:0];
    lk = $signed({{8{y[DATA_WIDTH-1]}}, y}) * LEAKY_K;
    case (mode)
      2'b10:   bn_lane = y[DATA_WIDTH-1] ? {DATA_WIDTH{1'b0}} : y;
      2'b11:   bn_lane = y[DATA_WIDTH-1] ? DATA_WIDTH'(lk >>> 8) : y;
      default: bn_lane = y;
    endcase
  endfunction

  state_t                 state_r;
  logic [1:0]             mode_r;
  logic [CH_W-1:0]        ch_m1_r, ch_cnt_r;
  logic [15:0]            beats_m1_r, beat_cnt_r;
  logic [DATA_WIDTH-1:0]  scale_mem_r [CHANNELS];
  logic [DATA_WIDTH-1:0]  bias_mem_r  [CHANNELS];
  logic                   s1_valid_r, s1_last_r, s2_valid_r, s2_last_r;
  logic [LW-1:0]          s1_data_r, s2_data_r, s3_data_s;
  logic [CH_W-1:0]        s1_ch_r, s2_ch_r;
  logic [DATA_WIDTH-1:0]  s1_scale_r, s1_bias_r, s2_bias_r;
  logic signed [PW-1:0]   s2_prod_r [LANES];
  logic                   advance_s, accept_s, last_beat_s;

  assign advance_s   = !out_valid | out_ready;
  assign in_ready    = (state_r == ST_RUN) & advance_s;
  assign accept_s    = in_valid & in_ready;
  assign last_beat_s = (ch_cnt_r == ch_m1_r) & (beat_cnt_r == beats_m1_r);
  assign busy        = (state_r != ST_IDLE);

  // Coefficient register file; writes only land while idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        scale_mem_r[i] <= DATA_WIDTH'(2 ** FRAC_BITS);
        bias_mem_r[i]  <= {DATA_WIDTH{1'b0}};
      end
    end else if (coef_we && state_r == ST_IDLE) begin
      scale_mem_r[coef_addr] <= coef_scale;
      bias_mem_r[coef_addr]  <= coef_bias;
    end
  end

  // Frame FSM, configuration latch and channel/beat sequencer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      mode_r     <= 2'b00;
      ch_m1_r    <= {CH_W{1'b0}};
      beats_m1_r <= 16'd0;
      ch_cnt_r   <= {CH_W{1'b0}};
      beat_cnt_r <= 16'd0;
      done       <= 1'b0;
      coef_err   <= 1'b0;
    end else begin
      done     <= 1'b0;
      coef_err <= coef_we & (state_r != ST_IDLE);
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            mode_r     <= cfg_mode;
            ch_m1_r    <= cfg_ch_m1;
            beats_m1_r <= cfg_beats_m1;
            ch_cnt_r   <= {CH_W{1'b0}};
            beat_cnt_r <= 16'd0;
            state_r    <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (accept_s) begin
            if (beat_cnt_r == beats_m1_r) begin
              beat_cnt_r <= 16'd0;
              ch_cnt_r   <= ch_cnt_r + {{(CH_W-1){1'b0}}, 1'b1};
            end else begin
              beat_cnt_r <= beat_cnt_r + 16'd1;
            end
            if (last_beat_s) state_r <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (out_valid && out_ready && out_last) begin
            state_r <= ST_IDLE;
            done    <= 1'b1;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Final-stage datapath: bypass passes the beat through untouched.
  always_comb begin
    s3_data_s = s2_data_r;
    if (mode_r != 2'b00) begin
      for (int l = 0; l < LANES; l++)
        s3_data_s[l*DATA_WIDTH +: DATA_WIDTH] = bn_lane(s2_prod_r[l], s2_bias_r, mode_r);
    end else begin
      s3_data_s = s2_data_r;
    end
  end

  // Three pipeline stages, all advancing together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_r <= 1'b0;
      s1_last_r  <= 1'b0;
      s1_data_r  <= {LW{1'b0}};
      s1_ch_r    <= {CH_W{1'b0}};
      s1_scale_r <= {DATA_WIDTH{1'b0}};
      s1_bias_r  <= {DATA_WIDTH{1'b0}};
      s2_valid_r <= 1'b0;
      s2_last_r  <= 1'b0;
      s2_data_r  <= {LW{1'b0}};
      s2_ch_r    <= {CH_W{1'b0}};
      s2_bias_r  <= {DATA_WIDTH{1'b0}};
      for (int l = 0; l < LANES; l++) s2_prod_r[l] <= {PW{1'b0}};
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_data   <= {LW{1'b0}};
      out_ch     <= {CH_W{1'b0}};
    end else if (advance_s) begin
      s1_valid_r <= accept_s;
      s1_last_r  <= last_beat_s;
      s1_data_r  <= in_data;
      s1_ch_r    <= ch_cnt_r;
      s1_scale_r <= scale_mem_r[ch_cnt_r];
      s1_bias_r  <= bias_mem_r[ch_cnt_r];
      s2_valid_r <= s1_valid_r;
      s2_last_r  <= s1_last_r;
      s2_data_r  <= s1_data_r;
      s2_ch_r    <= s1_ch_r;
      s2_bias_r  <= s1_bias_r;
      for (int l = 0; l < LANES; l++)
        s2_prod_r[l] <= mul_lane(s1_data_r[l*DATA_WIDTH +: DATA_WIDTH], s1_scale_r);
      out_valid  <= s2_valid_r;
      out_last   <= s2_last_r;
      out_data   <= s3_data_s;
      out_ch     <= s2_ch_r;
    end
  end
endmodule

// File: tb/tb_bn_stream_fold.sv
// Scoreboard bench for bn_stream_fold: stimulus pushes hand-computed results,
// a negedge monitor pops and compares every beat the DUT hands downstream.
module tb_bn_stream_fold;
  typedef struct packed {
    logic [127:0] data;
    logic [5:0]   ch;
    logic         last;
    logic         lat;
    logic [31:0]  cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   cfg_mode;
  logic [5:0]   cfg_ch_m1;
  logic [15:0]  cfg_beats_m1;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [127:0] out_data;
  logic [5:0]   out_ch;
  logic         out_last;
  logic         busy;
  logic         done;
  logic         coef_we;
  logic [5:0]   coef_addr;
  logic [15:0]  coef_scale;
  logic [15:0]  coef_bias;
  logic         coef_err;

  logic [31:0]  cyc = 32'd0;
  logic [31:0]  hold_until = 32'd0;
  logic         rnd_bp = 1'b0;
  int           pass_cnt = 0;
  int           total_cnt = 0;
  int           done_cnt = 0;
  int           frame_done0 = 0;
  exp_t         sb[$];

  bn_stream_fold dut (
    .clk(clk), .reset(reset), .start(start), .cfg_mode(cfg_mode), .cfg_ch_m1(cfg_ch_m1),
    .cfg_beats_m1(cfg_beats_m1), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch),
    .out_last(out_last), .busy(busy), .done(done), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_scale(coef_scale), .coef_bias(coef_bias), .coef_err(coef_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 32'd1;

  // Downstream ready: forced low during a hold window, otherwise steady or random.
  always @(posedge clk) begin
    #1;
    if (cyc < hold_until) out_ready = 1'b0;
    else if (rnd_bp) out_ready = 1'($urandom_range(0, 1));
    else out_ready = 1'b1;
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [127:0] lanes(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    lanes = {a, a, a, a, a, c, b, a};
  endfunction

  function automatic logic [127:0] beat_data(input int b);
    for (int l = 0; l < 8; l++) beat_data[l*16 +: 16] = 16'(b * 256 + l * 16 + 1);
  endfunction

  // Monitor: scoreboard compare on every downstream handshake, plus stall and done tracking.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      if (done) done_cnt++;
      if (out_valid && !out_ready) chk("stall_in_ready", 128'(in_ready), 128'(0));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_beat: got %h expected no beat", out_data);
        end else begin
          e = sb.pop_front();
          chk("out_data", out_data, e.data);
          chk("out_ch", 128'(out_ch), 128'(e.ch));
          chk("out_last", 128'(out_last), 128'(e.last));
          if (e.lat) chk("latency", 128'(cyc - e.cyc), 128'(3));
        end
      end
    end
  end

  task automatic coef_write(input logic [5:0] a, input logic [15:0] s, input logic [15:0] b);
    coef_we = 1'b1; coef_addr = a; coef_scale = s; coef_bias = b;
    @(posedge clk); #1;
    coef_we = 1'b0;
  endtask

  task automatic start_frame(input logic [1:0] m, input logic [5:0] c, input logic [15:0] b);
    frame_done0 = done_cnt;
    start = 1'b1; cfg_mode = m; cfg_ch_m1 = c; cfg_beats_m1 = b;
    @(posedge clk); #1;
    start = 1'b0;
    coef_we = 1'b0;
    chk("busy_run", 128'(busy), 128'(1));
  endtask

  task automatic send_beat(input logic [127:0] d, input logic [127:0] x, input logic [5:0] c,
                           input logic last, input logic lat);
    bit ok = 1'b0;
    in_valid = 1'b1; in_data = d;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back('{data: x, ch: c, last: last, lat: lat, cyc: cyc});
        ok = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!ok) begin
      total_cnt++;
      $display("FAIL beat_accept: got no in_ready expected acceptance within 300 cycles");
    end
  endtask

  task automatic finish_frame();
    bit idle = 1'b0;
    for (int i = 0; i < 300 && !idle; i++) begin
      @(negedge clk);
      if (!busy) idle = 1'b1;
    end
    if (!idle) begin
      total_cnt++;
      $display("FAIL frame_drain: got busy=1 expected busy=0 within 300 cycles");
    end
    @(posedge clk); #1;
    chk("done_pulse", 128'(done_cnt), 128'(frame_done0 + 1));
    chk("sb_drained", 128'(sb.size()), 128'(0));
  endtask

  initial begin
    logic [127:0] d;
    int           dc0;
    reset = 1'b0; start = 1'b0; cfg_mode = 2'b00; cfg_ch_m1 = 6'd0; cfg_beats_m1 = 16'd0;
    in_valid = 1'b0; in_data = 128'd0; coef_we = 1'b0; coef_addr = 6'd0;
    coef_scale = 16'd0; coef_bias = 16'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_data", out_data, 128'(0));
    chk("rst_out_ch", 128'(out_ch), 128'(0));
    chk("rst_out_last", 128'(out_last), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_coef_err", 128'(coef_err), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(0));
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;

    // default coefficients: identity
    start_frame(2'b01, 6'd0, 16'd0);
    send_beat(lanes(16'h0300, 16'h0300, 16'h0300), lanes(16'h0300, 16'h0300, 16'h0300), 6'd0, 1'b1, 1'b1);
    finish_frame();

    // 3 channels x 4 beats, free-flowing
    start_frame(2'b01, 6'd2, 16'd3);
    for (int b = 0; b < 12; b++) send_beat(beat_data(b), beat_data(b), 6'(b / 4), b == 11, 1'b1);
    finish_frame();

    // same frame under random backpressure with a 10-cycle hold
    rnd_bp = 1'b1;
    start_frame(2'b01, 6'd2, 16'd3);
    for (int b = 0; b < 12; b++) begin
      if (b == 5) hold_until = cyc + 32'd10;
      send_beat(beat_data(b + 20), beat_data(b + 20), 6'(b / 4), b == 11, 1'b0);
    end
    finish_frame();
    rnd_bp = 1'b0;
    repeat (2) @(posedge clk); #1;

    // per-channel scale/bias with rounding
    coef_write(6'd1, 16'h0180, 16'h0000);
    coef_write(6'd2, 16'h0200, 16'hFF00);
    d = lanes(16'h0180, 16'h0001, 16'hFFFF);
    start_frame(2'b01, 6'd2, 16'd0);
    send_beat(d, d, 6'd0, 1'b0, 1'b1);
    send_beat(d, lanes(16'h0240, 16'h0002, 16'hFFFF), 6'd1, 1'b0, 1'b1);
    send_beat(d, lanes(16'h0200, 16'hFF02, 16'hFEFE), 6'd2, 1'b1, 1'b1);
    finish_frame();

    // write and start in the same idle cycle; positive saturation
    coef_we = 1'b1; coef_addr = 6'd0; coef_scale = 16'h7FFF; coef_bias = 16'h0000;
    start_frame(2'b01, 6'd0, 16'd0);
    send_beat(lanes(16'h0200, 16'h0200, 16'h0200), lanes(16'h7FFF, 16'h7FFF, 16'h7FFF), 6'd0, 1'b1, 1'b1);
    finish_frame();

    // activation modes on 1.0 / 3.0 / -128.0 with scale 2.0, bias -4.0
    coef_write(6'd0, 16'h0200, 16'hFC00);
    d = lanes(16'h0100, 16'h0300, 16'h8000);
    start_frame(2'b01, 6'd0, 16'd0);
    send_beat(d, lanes(16'hFE00, 16'h0200, 16'h8000), 6'd0, 1'b1, 1'b1);
    finish_frame();
    start_frame(2'b10, 6'd0, 16'd0);
    send_beat(d, lanes(16'h0000, 16'h0200, 16'h0000), 6'd0, 1'b1, 1'b1);
    finish_frame();
    start_frame(2'b11, 6'd0, 16'd0);
    send_beat(d, lanes(16'hFFCC, 16'h0200, 16'hF300), 6'd0, 1'b1, 1'b1);
    finish_frame();
    start_frame(2'b00, 6'd0, 16'd0);
    send_beat(d, d, 6'd0, 1'b1, 1'b1);
    finish_frame();

    // write while busy is dropped and flagged
    start_frame(2'b01, 6'd0, 16'd1);
    coef_we = 1'b1; coef_addr = 6'd0; coef_scale = 16'h0100; coef_bias = 16'h0000;
    @(negedge clk);
    chk("coef_err_before", 128'(coef_err), 128'(0));
    @(posedge clk); #1 coef_we = 1'b0;
    @(negedge clk);
    chk("coef_err_pulse", 128'(coef_err), 128'(1));
    @(negedge clk);
    chk("coef_err_clear", 128'(coef_err), 128'(0));
    @(posedge clk); #1;
    send_beat(d, lanes(16'hFE00, 16'h0200, 16'h8000), 6'd0, 1'b0, 1'b1);
    send_beat(d, lanes(16'hFE00, 16'h0200, 16'h8000), 6'd0, 1'b1, 1'b1);
    finish_frame();

    // abort mid-frame with reset
    start_frame(2'b01, 6'd3, 16'd0);
    send_beat(d, d, 6'd0, 1'b0, 1'b0);
    send_beat(d, d, 6'd1, 1'b0, 1'b0);
    reset = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    dc0 = done_cnt;
    @(negedge clk);
    chk("abort_out_valid", 128'(out_valid), 128'(0));
    chk("abort_out_data", out_data, 128'(0));
    chk("abort_out_ch", 128'(out_ch), 128'(0));
    chk("abort_busy", 128'(busy), 128'(0));
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("abort_no_done", 128'(done_cnt), 128'(dc0));

    // coefficients back at 1.0 / 0 after reset
    start_frame(2'b01, 6'd2, 16'd0);
    send_beat(d, d, 6'd0, 1'b0, 1'b1);
    send_beat(d, d, 6'd1, 1'b0, 1'b1);
    send_beat(d, d, 6'd2, 1'b1, 1'b1);
    finish_frame();

    repeat (5) @(posedge clk);
    #1;
    chk("final_sb_empty", 128'(sb.size()), 128'(0));
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
